// File: rtl/sdcram_dma_if.sv
// sdcram_dma_if: sdcram word-interface bundle between the DMA initiator (master)
// and the SD-backed RAM responder (slave).
interface sdcram_dma_if;
    logic [40:0] w_sdcram_addr;
    logic        w_sdcram_ren;
    logic [3:0]  w_sdcram_wen;
    logic [31:0] w_sdcram_wdata;
    logic [31:0] w_sdcram_rdata;
    logic        w_sdcram_busy;

    modport master (
        output w_sdcram_addr, w_sdcram_ren, w_sdcram_wen, w_sdcram_wdata,
        input  w_sdcram_rdata, w_sdcram_busy
    );

    modport slave (
        input  w_sdcram_addr, w_sdcram_ren, w_sdcram_wen, w_sdcram_wdata,
        output w_sdcram_rdata, w_sdcram_busy
    );
endinterface

// File: rtl/sdcram_dma.sv
// sdcram_dma: block copy of 32-bit words between sdcram and a local single-port
// memory, one word at a time, in either direction.
module sdcram_dma #(
    parameter int LEN_W  = 16,
    parameter int MEM_AW = 32
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic              i_start,
    input  logic              i_dir,
    input  logic [40:0]       i_sd_addr,
    input  logic [MEM_AW-1:0] i_mem_addr,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [LEN_W-1:0]  o_cnt,
    sdcram_dma_if.master      sd,
    output logic [MEM_AW-1:0] m_addr,
    output logic              m_re,
    output logic              m_we,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);
    typedef enum logic [2:0] {IDLE, MRD, MCAP, SDREQ, SDWAIT, MWR, ADV, DONE} state_t;

    state_t            state_q, state_d;
    logic [40:0]       sd_q, sd_d;
    logic [MEM_AW-1:0] mem_q, mem_d;
    logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
    logic [31:0]       word_q, word_d;
    logic              dir_q, dir_d, err_q, err_d;

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state_q <= IDLE;
            sd_q    <= '0;
            mem_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sd_q    <= sd_d;
            mem_q   <= mem_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sd_d    = sd_q;
        mem_d   = mem_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        dir_d   = dir_q;
        err_d   = err_q;
        sd.w_sdcram_ren = 1'b0;
        sd.w_sdcram_wen = 4'h0;
        m_re = 1'b0;
        m_we = 1'b0;
        case (state_q)
            IDLE: if (i_start) begin
                if (|i_sd_addr[1:0] || |i_mem_addr[1:0]) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (i_len == '0) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    sd_d    = i_sd_addr;
                    mem_d   = i_mem_addr;
                    len_d   = i_len;
                    dir_d   = i_dir;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = i_dir ? MRD : SDREQ;
                end
            end
            MRD: begin
                m_re    = 1'b1;
                state_d = MCAP;
            end
            MCAP: begin
                word_d  = m_rdata;
                state_d = SDREQ;
            end
            // A request is only raised on a cycle the responder can accept it.
            SDREQ: if (!sd.w_sdcram_busy) begin
                sd.w_sdcram_ren = !dir_q;
                sd.w_sdcram_wen = {4{dir_q}};
                state_d = SDWAIT;
            end
            SDWAIT: if (!sd.w_sdcram_busy) begin
                word_d  = dir_q ? word_q : sd.w_sdcram_rdata;
                state_d = dir_q ? ADV : MWR;
            end
            MWR: begin
                m_we    = 1'b1;
                state_d = ADV;
            end
            ADV: begin
                sd_d    = sd_q + 41'd4;
                mem_d   = mem_q + MEM_AW'(4);
                cnt_d   = cnt_q + LEN_W'(1);
                state_d = (cnt_d == len_q) ? DONE : (dir_q ? MRD : SDREQ);
            end
            default: state_d = IDLE;
        endcase
    end

    assign sd.w_sdcram_addr  = sd_q;
    assign sd.w_sdcram_wdata = word_q;
    assign m_addr  = mem_q;
    assign m_wdata = word_q;
    assign o_busy  = state_q != IDLE && state_q != DONE;
    assign o_done  = state_q == DONE;
    assign o_err   = err_q;
    assign o_cnt   = cnt_q;
endmodule

// File: tb/tb_sdcram_dma.sv
// tb_sdcram_dma: directed vector table plus hand sequences for stall, reset abort
// and start-while-busy, against a latency-programmable sdcram responder model.
module tb_sdcram_dma;
    logic        CLK = 1'b0;
    logic        RST_X = 1'b0;
    logic        i_start = 1'b0;
    logic        i_dir = 1'b0;
    logic [40:0] i_sd_addr = '0;
    logic [31:0] i_mem_addr = '0;
    logic [15:0] i_len = '0;
    logic        o_busy, o_done, o_err;
    logic [15:0] o_cnt;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_re, m_we;

    always #5 CLK = ~CLK;

    sdcram_dma_if sd ();

    sdcram_dma #(.LEN_W(16), .MEM_AW(32)) dut (
        .CLK(CLK), .RST_X(RST_X), .i_start(i_start), .i_dir(i_dir),
        .i_sd_addr(i_sd_addr), .i_mem_addr(i_mem_addr), .i_len(i_len),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_cnt(o_cnt),
        .sd(sd), .m_addr(m_addr), .m_re(m_re), .m_we(m_we),
        .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    logic [31:0] sdm [0:1023];
    logic [31:0] lm  [0:16383];
    bit loaded_s = 1'b0;
    bit loaded_m = 1'b0;
    int lat = 1;
    int stall_req = 0;
    int busy_cnt = 0;
    int n_acc = 0;
    int n_viol = 0;
    int n_mwe = 0;

    assign sd.w_sdcram_busy = busy_cnt != 0;

    // Responder: busy for `lat` cycles after each accepted request.
    always @(posedge CLK) begin
        if (!loaded_s) begin
            for (int i = 0; i < 1024; i++) sdm[i] <= 32'h5A5A0000 ^ i;
            sdm[64] <= 32'h11111111;
            sdm[65] <= 32'h22222222;
            sdm[66] <= 32'h33333333;
            sd.w_sdcram_rdata <= '0;
            loaded_s <= 1'b1;
        end else begin
            if ((sd.w_sdcram_ren || |sd.w_sdcram_wen) && busy_cnt != 0) n_viol <= n_viol + 1;
            if (stall_req != 0) busy_cnt <= stall_req;
            else if ((sd.w_sdcram_ren || |sd.w_sdcram_wen) && busy_cnt == 0) begin
                busy_cnt <= lat;
                n_acc <= n_acc + 1;
                if (sd.w_sdcram_ren) sd.w_sdcram_rdata <= sdm[sd.w_sdcram_addr[11:2]];
                else sdm[sd.w_sdcram_addr[11:2]] <= sd.w_sdcram_wdata;
            end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        end
    end

    always @(posedge CLK) begin
        if (!loaded_m) begin
            for (int i = 0; i < 16384; i++) lm[i] <= ~i;
            lm[16] <= 32'hDEADBEEF;
            lm[17] <= 32'hCAFEF00D;
            m_rdata <= '0;
            loaded_m <= 1'b1;
        end else begin
            if (m_re) m_rdata <= lm[m_addr[15:2]];
            if (m_we) begin
                lm[m_addr[15:2]] <= m_wdata;
                n_mwe <= n_mwe + 1;
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return {37'd0, o_busy, o_done, o_err, o_cnt, |sd.w_sdcram_addr, sd.w_sdcram_ren,
                |sd.w_sdcram_wen, |sd.w_sdcram_wdata, |m_addr, m_re, m_we, |m_wdata};
    endfunction

    task automatic run_cmd(input logic dir, input logic [40:0] sa, input logic [31:0] ma,
                           input logic [15:0] len, output int done_at, output int ndone);
        i_dir = dir;
        i_sd_addr = sa;
        i_mem_addr = ma;
        i_len = len;
        i_start = 1'b1;
        done_at = -1;
        ndone = 0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            i_start = 1'b0;
            if (o_done) begin
                if (done_at < 0) done_at = c;
                ndone++;
            end
            if (done_at >= 0 && !o_done && !o_busy) break;
        end
    endtask

    typedef struct {
        logic        dir;
        logic [40:0] sa;
        logic [31:0] ma;
        logic [15:0] len;
        logic        exp_err;
        int          exp_done;
        int          exp_acc;
        int          exp_mwe;
        logic        chk_cnt;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t v [5];

    initial begin
        int da, nd, a0, m0, x0;
        v[0] = '{1'b0, 41'h100, 32'h2000, 16'd3, 1'b0, 16, 3, 3, 1'b1, 16'd3};
        v[1] = '{1'b1, 41'h800, 32'h40,   16'd2, 1'b0, 13, 2, 0, 1'b1, 16'd2};
        v[2] = '{1'b0, 41'h100, 32'h2000, 16'd0, 1'b0, 1,  0, 0, 1'b0, 16'd0};
        v[3] = '{1'b0, 41'h102, 32'h2000, 16'd4, 1'b1, 1,  0, 0, 1'b0, 16'd0};
        v[4] = '{1'b1, 41'h100, 32'h3,    16'd4, 1'b1, 1,  0, 0, 1'b0, 16'd0};

        RST_X = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", outs(), 64'd0);
        RST_X = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            a0 = n_acc; m0 = n_mwe; x0 = n_viol;
            run_cmd(v[i].dir, v[i].sa, v[i].ma, v[i].len, da, nd);
            chk($sformatf("v%0d_done_cycle", i), da, v[i].exp_done);
            chk($sformatf("v%0d_done_pulses", i), nd, 1);
            chk($sformatf("v%0d_err", i), o_err, v[i].exp_err);
            chk($sformatf("v%0d_sd_requests", i), n_acc - a0, v[i].exp_acc);
            chk($sformatf("v%0d_mem_writes", i), n_mwe - m0, v[i].exp_mwe);
            chk($sformatf("v%0d_req_while_busy", i), n_viol - x0, 0);
            if (v[i].chk_cnt) chk($sformatf("v%0d_cnt", i), o_cnt, v[i].exp_cnt);
            tick();
        end
        chk("sd2mem_w0", lm[32'h2000 >> 2], 32'h11111111);
        chk("sd2mem_w1", lm[32'h2004 >> 2], 32'h22222222);
        chk("sd2mem_w2", lm[32'h2008 >> 2], 32'h33333333);
        chk("mem2sd_w0", sdm[32'h800 >> 2], 32'hDEADBEEF);
        chk("mem2sd_w1", sdm[32'h804 >> 2], 32'hCAFEF00D);

        // Responder already busy when the command arrives.
        lat = 10;
        stall_req = 10;
        tick();
        stall_req = 0;
        a0 = n_acc; m0 = n_mwe; x0 = n_viol;
        run_cmd(1'b0, 41'h108, 32'h3000, 16'd1, da, nd);
        chk("stall_done_pulses", nd, 1);
        chk("stall_sd_requests", n_acc - a0, 1);
        chk("stall_req_while_busy", n_viol - x0, 0);
        chk("stall_mem_writes", n_mwe - m0, 1);
        chk("stall_word", lm[32'h3000 >> 2], 32'h33333333);
        chk("stall_cnt", o_cnt, 16'd1);
        tick();

        // Reset mid-transfer while the responder is still busy.
        lat = 8;
        i_dir = 1'b0; i_sd_addr = 41'h100; i_mem_addr = 32'h6000; i_len = 16'd5;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (3) tick();
        chk("pre_reset_busy", o_busy, 1'b1);
        RST_X = 1'b0;
        repeat (3) tick();
        chk("midreset_outputs", outs(), 64'd0);
        RST_X = 1'b1;
        chk("resp_busy_after_reset", sd.w_sdcram_busy, 1'b1);
        a0 = n_acc; m0 = n_mwe; x0 = n_viol;
        run_cmd(1'b0, 41'h104, 32'h7000, 16'd1, da, nd);
        chk("postreset_done_pulses", nd, 1);
        chk("postreset_sd_requests", n_acc - a0, 1);
        chk("postreset_req_while_busy", n_viol - x0, 0);
        chk("postreset_word", lm[32'h7000 >> 2], 32'h22222222);
        chk("postreset_mem_writes", n_mwe - m0, 1);
        tick();

        // i_start during a transfer is ignored.
        lat = 1;
        a0 = n_acc; m0 = n_mwe;
        i_dir = 1'b0; i_sd_addr = 41'h100; i_mem_addr = 32'h5000; i_len = 16'd1;
        i_start = 1'b1;
        da = -1;
        for (int c = 1; c <= 50; c++) begin
            tick();
            i_start = (c == 2);
            if (c == 2) begin
                i_dir = 1'b1; i_sd_addr = 41'h800; i_len = 16'd3;
            end
            if (o_done && da < 0) da = c;
            if (da >= 0 && !o_done) break;
        end
        chk("ignore_done_cycle", da, 6);
        chk("ignore_sd_requests", n_acc - a0, 1);
        chk("ignore_mem_writes", n_mwe - m0, 1);
        chk("ignore_cnt", o_cnt, 16'd1);
        chk("ignore_word", lm[32'h5000 >> 2], 32'h11111111);
        chk("ignore_idle", o_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/sdcram_dma.md
Name: sdcram_dma

Overview:
- Block-transfer initiator for the sdcram word interface, on the master side of an SD-backed RAM responder.
- Copies a run of 32-bit words between sdcram and a local single-port memory (main memory or scratch BRAM), in either direction.
- Started by a one-cycle command from the MMIO controller. Reports busy/done/error and a progress count back to it.

Parameters:
- LEN_W, 16, width of the word-count command and of o_cnt.
- MEM_AW, 32, local memory byte-address width.

Ports:
- CLK  in  1  system clock.
- RST_X  in  1  synchronous, active-low reset.
- i_start  in  1  command strobe. Sampled only in IDLE.
- i_dir  in  1  0 = sdcram→mem, 1 = mem→sdcram.
- i_sd_addr  in  41  sdcram start byte address.
- i_mem_addr  in  MEM_AW  local memory start byte address.
- i_len  in  LEN_W  number of 32-bit words to copy.
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  alignment error flag for the last command.
- o_cnt  out  LEN_W  words completed in the current or last command.
- w_sdcram_addr  out  41  request byte address.
- w_sdcram_ren  out  1  read request.
- w_sdcram_wen  out  4  byte write enables.
- w_sdcram_wdata  out  32  write data.
- w_sdcram_rdata  in  32  read data.
- w_sdcram_busy  in  1  responder busy.
- m_addr  out  MEM_AW  local memory byte address.
- m_re  out  1  local read enable. Read data is valid exactly 1 cycle later.
- m_we  out  1  local full-word write enable.
- m_wdata  out  32  local write data.
- m_rdata  in  32  local read data.

Behaviour:
- Reset: state IDLE. All outputs 0: ren, wen, m_re, m_we, o_busy, o_done, o_err, o_cnt, addresses, data.
- Reset mid-transfer aborts the command immediately. The responder may still be busy; the next request waits for it (see SDREQ).
- sdcram protocol:
  - A request is accepted on a cycle where ren or |wen is high and w_sdcram_busy = 0.
  - The responder raises busy the cycle after acceptance and lowers it when the access completes.
  - rdata is valid from the first cycle busy is low after acceptance.
  - ren/wen are asserted for exactly the accept cycle, never while busy = 1.
- IDLE, i_start = 1:
  - If i_sd_addr[1:0] ≠ 0 or i_mem_addr[1:0] ≠ 0: o_err ← 1, go to DONE. No requests are issued.
  - Else if i_len = 0: o_err ← 0, go to DONE.
  - Else: latch addresses, length and direction; clear o_err and o_cnt. Go to SDREQ if i_dir = 0, MRD if i_dir = 1.
- MRD: m_re = 1, m_addr = current mem address → MCAP.
- MCAP: latch m_rdata into the word register → SDREQ.
- SDREQ:
  - Drives w_sdcram_addr = current sd address.
  - When busy = 0: asserts ren (i_dir = 0) or wen = 4'hF with wdata = word register (i_dir = 1), then → SDWAIT.
  - When busy = 1: holds SDREQ with ren/wen low.
- SDWAIT: stay while busy = 1. When busy = 0:
  - i_dir = 0: latch rdata into the word register → MWR.
  - i_dir = 1: word complete → ADV.
- MWR: m_we = 1, m_addr = current mem address, m_wdata = word register → ADV.
- ADV:
  - sd address += 4 (wraps mod 2^41). mem address += 4 (wraps mod 2^MEM_AW). o_cnt += 1.
  - If o_cnt + 1 = length → DONE, else → SDREQ (dir 0) / MRD (dir 1).
- DONE: o_done = 1 for one cycle → IDLE.
- o_busy = 1 in every state except IDLE and DONE.
- o_cnt and o_err hold their values after DONE until the next accepted i_start.
- i_start outside IDLE is ignored.
- Throughput with a 1-cycle-busy responder: 5 cycles/word for dir 0, 6 cycles/word for dir 1.

Test Plan:
- Reset: hold RST_X = 0 for 3 cycles mid-transfer → next cycle all outputs 0, state IDLE. The next command starts cleanly after busy drops.
- sd→mem: sd 0x100 preloaded 0x11111111, 0x22222222, 0x33333333; mem 0x2000, len 3, start at cycle 0 →
  - ren pulses (1 cycle each) at addr 0x100, 0x104, 0x108;
  - m_we writes those words to 0x2000, 0x2004, 0x2008;
  - o_done at cycle 16; o_cnt = 3.
- mem→sd: mem 0x40 = 0xDEADBEEF, 0xCAFEF00D; sd 0x800, len 2 →
  - wen = 4'hF at 0x800 then 0x804 with matching wdata;
  - sd readback matches; o_done once; o_cnt = 2.
- Stall: responder holds busy 10 cycles per access and is already busy when start arrives, len 1 dir 0 →
  - ren stays low until busy = 0, then exactly one ren pulse;
  - correct word written; no duplicate requests.
- len = 0 → o_done at cycle 1, o_err = 0, no ren/wen/m_we.
- Misaligned: i_sd_addr = 0x102 (and separately i_mem_addr = 0x3) → o_err = 1, o_done at cycle 1, no requests. i_start while o_busy = 1 has no effect.
